// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the fetch/decode path.
// Holds the request mode encodings for jump_target_unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        JT_JUMP   = 2'd0,
        JT_BRANCH = 2'd1,
        JT_JREG   = 2'd2,
        JT_RET    = 2'd3
    } jt_mode_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with a top pointer and a count that saturates at RAS_DEPTH.
// A push when full overwrites the oldest entry. A pop together with a push replaces the top in place.
module ret_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              flush,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic              replace_top;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;

    assign top   = mem[top_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(RAS_DEPTH));

    // A pop on an empty stack does nothing, so pop+push then acts as a plain push.
    assign replace_top = push && pop && !empty;

    always_comb begin
        wr_en  = 1'b0;
        wr_ptr = top_ptr + PTR_W'(1);
        if (push && !flush) begin
            wr_en  = 1'b1;
            wr_ptr = replace_top ? top_ptr : top_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && !replace_top) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !push && !empty) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/jump_target_unit.sv
// Next-PC target generator for jumps, branches, register jumps and predicted returns.
// The target is held in a one-entry output register with a valid/ready handshake.
module jump_target_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 26,
    parameter int OFF_W     = 16,
    parameter int SHIFT     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic              in_link,
    input  logic [ADDR_W-1:0] in_pc4,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic              ras_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_target,
    output logic              out_ras_miss
);

    localparam int HI_W = ADDR_W - IDX_W - SHIFT;

    logic              accept;
    logic [ADDR_W-1:0] idx_ext;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic [ADDR_W-1:0] next_target;
    logic              next_miss;

    // Requests arriving while rst is high are never accepted.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign idx_ext = ADDR_W'(in_index) << SHIFT;

    generate
        if (HI_W > 0) begin : g_jump_hi
            assign jump_tgt = {in_pc4[ADDR_W-1 -: HI_W], idx_ext[ADDR_W-HI_W-1:0]};
        end else begin : g_jump_full
            assign jump_tgt = idx_ext;
        end
    endgenerate

    assign br_off = ADDR_W'($signed(in_index[OFF_W-1:0])) << SHIFT;
    assign br_tgt = in_pc4 + br_off;

    always_comb begin
        next_target = '0;
        next_miss   = 1'b0;
        case (jt_mode_e'(in_mode))
            JT_JUMP:   next_target = jump_tgt;
            JT_BRANCH: next_target = br_tgt;
            JT_JREG:   next_target = in_reg;
            JT_RET: begin
                next_target = ras_empty ? in_reg : ras_top;
                next_miss   = ras_empty;
            end
            default:   next_target = '0;
        endcase
    end

    ret_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && in_link),
        .pop       (accept && (in_mode == JT_RET)),
        .push_data (in_pc4),
        .flush     (ras_flush),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_target   <= '0;
            out_ras_miss <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_target   <= next_target;
            out_ras_miss <= next_miss;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jump_target_unit.sv
// Randomized scoreboard bench for jump_target_unit against a queue-based reference model.
module tb_jump_target_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'd0;
    logic        in_link = 1'b0;
    logic [31:0] in_pc4 = '0;
    logic [25:0] in_index = '0;
    logic [31:0] in_reg = '0;
    logic        ras_flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_target;
    logic        out_ras_miss;

    typedef struct {
        logic [31:0] target;
        logic        miss;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ras_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rdy_pct = 100;
    int          stall_cnt = 0;

    jump_target_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_link      (in_link),
        .in_pc4       (in_pc4),
        .in_index     (in_index),
        .in_reg       (in_reg),
        .ras_flush    (ras_flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_target   (out_target),
        .out_ras_miss (out_ras_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_ready();
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        in_valid  = 1'b0;
        ras_flush = 1'b0;
        drive_ready();
        #1;
    endtask

    // Reference: targets from the instruction rules; RAS as a list, newest at the back.
    task automatic model_accept(input logic [1:0] m, input logic lk, input logic [31:0] pc4,
                                input logic [25:0] idx, input logic [31:0] rg, input logic fl);
        exp_t e;
        int   off;
        int   soff;
        e.miss = 1'b0;
        case (m)
            2'd0: e.target = (pc4 & 32'hF000_0000) | (32'(idx) * 4);
            2'd1: begin
                off  = int'(idx & 26'h000FFFF);
                soff = (off >= 32768) ? off - 65536 : off;
                e.target = 32'(longint'(pc4) + longint'(soff) * 4);
            end
            2'd2: e.target = rg;
            default: begin
                if (ras_q.size() > 0) begin
                    e.target = ras_q[$];
                end else begin
                    e.target = rg;
                    e.miss   = 1'b1;
                end
            end
        endcase
        exp_q.push_back(e);
        if (fl) begin
            ras_q.delete();
        end else begin
            if (m == 2'd3 && ras_q.size() > 0) void'(ras_q.pop_back());
            if (lk) begin
                ras_q.push_back(pc4);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic lk, input logic [31:0] pc4,
                         input logic [25:0] idx, input logic [31:0] rg, input logic fl);
        int n = 0;
        @(negedge clk);
        drive_ready();
        in_valid  = 1'b1;
        in_mode   = m;
        in_link   = lk;
        in_pc4    = pc4;
        in_index  = idx;
        in_reg    = rg;
        ras_flush = 1'b0;
        #1;
        while (!in_ready) begin
            if (n >= 200) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                return;
            end
            n++;
            @(negedge clk);
            drive_ready();
            #1;
        end
        // Flush is raised only once acceptance is certain so the target sees the pre-flush stack.
        ras_flush = fl;
        model_accept(m, lk, pc4, idx, rg, fl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        stall_cnt = 0;
        in_valid  = 1'b1;
        in_mode   = 2'd2;
        in_link   = 1'b1;
        in_pc4    = 32'h000D_EAD0;
        ras_flush = 1'b0;
        exp_q.delete();
        ras_q.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        drive_ready();
        #1;
        chk("valid_after_rst", 32'(out_valid), 32'd0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("target", out_target, exp_q[0].target);
                    chk("ras_miss", 32'(out_ras_miss), 32'(exp_q[0].miss));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_miss", 32'(out_ras_miss), 32'd0);

        issue(2'd0, 1'b0, 32'h4000_0010, 26'h123, 32'h0, 1'b0);
        issue(2'd1, 1'b0, 32'h0000_1000, 26'h000FFFE, 32'h0, 1'b0);
        issue(2'd1, 1'b0, 32'h0000_0004, 26'h000FFFE, 32'h0, 1'b0);

        issue(2'd2, 1'b1, 32'h100, 26'h0, 32'h1234, 1'b0);
        issue(2'd2, 1'b1, 32'h200, 26'h0, 32'h1234, 1'b0);
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h11, 1'b0);
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h22, 1'b0);
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h55, 1'b0);

        for (int i = 1; i <= 5; i++) issue(2'd2, 1'b1, 32'(i * 16), 26'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h99, 1'b0);

        // Held RET: the second RET waits out the stall and must pop exactly once.
        issue(2'd2, 1'b1, 32'hA0, 26'h0, 32'h0, 1'b0);
        issue(2'd2, 1'b1, 32'hB0, 26'h0, 32'h0, 1'b0);
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h99, 1'b0);
        stall_cnt = 3;
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h99, 1'b0);
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h98, 1'b0);

        issue(2'd2, 1'b1, 32'h300, 26'h0, 32'h0, 1'b0);
        issue(2'd2, 1'b1, 32'h400, 26'h0, 32'h0, 1'b0);
        tick();
        stall_cnt = 5;
        issue(2'd0, 1'b0, 32'h0, 26'h3, 32'h0, 1'b0);
        do_reset();
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h77, 1'b0);

        issue(2'd2, 1'b1, 32'h600, 26'h0, 32'h0, 1'b0);
        issue(2'd2, 1'b1, 32'h700, 26'h0, 32'h0, 1'b0);
        issue(2'd3, 1'b1, 32'h800, 26'h0, 32'h0, 1'b1);
        issue(2'd3, 1'b0, 32'h0, 26'h0, 32'h88, 1'b0);

        rdy_pct = 70;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 2) begin
                do_reset();
            end else if (r < 12) begin
                tick();
            end else begin
                issue(2'($urandom_range(3)), ($urandom_range(3) == 0), $urandom,
                      26'($urandom), $urandom, ($urandom_range(19) == 0));
            end
        end

        rdy_pct = 100;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
